reg_file_32: RTL and testbench

REG_FILE_32 -- requirements
Module: reg_file_32

---
 rtl/reg_file_32.sv | 116 +++++++++++
 tb/tb_reg_file_32.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_32.sv
// rtl/reg_file_32.sv - 2**ADDR_W x DATA_W register file, two registered read ports, sequenced clear
// Optional REG_ZERO_EN: entry 0 hardwired to zero (writes discarded, reads return 0).
module reg_file_32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic              clr,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;

  logic              clr_active;
  logic              clr_start;
  logic              wr_commit;
  logic [DATA_W-1:0] nxt_a;
  logic [DATA_W-1:0] nxt_b;

  assign clr_active = (state == ST_CLEAR);
  assign clr_start  = (state == ST_IDLE) && clr;

`ifdef REG_ZERO_EN
  assign wr_commit  = (state == ST_IDLE) && we && !clr && (wr_addr != '0);
`else
  assign wr_commit  = (state == ST_IDLE) && we && !clr;
`endif

  assign busy = clr_active;

  // Read ports see the entry as it stands after this edge: clear beats write, write beats stored value.
  always_comb begin
    nxt_a = mem[rd_addr_a];
    if (clr_active && (cnt == rd_addr_a)) begin
      nxt_a = '0;
    end else if (wr_commit && (wr_addr == rd_addr_a)) begin
      nxt_a = wr_data;
    end
`ifdef REG_ZERO_EN
    if (rd_addr_a == '0) begin
      nxt_a = '0;
    end
`endif
  end

  always_comb begin
    nxt_b = mem[rd_addr_b];
    if (clr_active && (cnt == rd_addr_b)) begin
      nxt_b = '0;
    end else if (wr_commit && (wr_addr == rd_addr_b)) begin
      nxt_b = wr_data;
    end
`ifdef REG_ZERO_EN
    if (rd_addr_b == '0) begin
      nxt_b = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_active) begin
      mem[cnt] <= '0;
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Single pass over the array; the counter parks at 0 once the last entry is zeroed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else if (clr_active) begin
      if (cnt == LAST_ADDR) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt   <= cnt + ADDR_W'(1);
      end
    end else if (clr_start) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= nxt_a;
      rd_data_b <= nxt_b;
    end
  end

endmodule

// File: tb/tb_reg_file_32.sv
// tb/tb_reg_file_32.sv - scoreboard bench for reg_file_32
// Expected read data is queued at issue time and popped by an independent monitor.
module tb_reg_file_32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr_a = '0;
  logic [4:0]  rd_addr_b = '0;
  logic        clr = 1'b0;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] qa [$];
  logic [31:0] qb [$];
  string       qn [$];
  logic        rd_chk = 1'b0;
  logic        chk_d = 1'b0;
  logic        count_en = 1'b0;
  int          busy_cycles = 0;

`ifdef REG_ZERO_EN
  localparam logic [31:0] FILL0 = 32'h0000_0000;
  localparam logic [31:0] BEEF0 = 32'h0000_0000;
`else
  localparam logic [31:0] FILL0 = 32'hFFFF_FFFF;
  localparam logic [31:0] BEEF0 = 32'hDEAD_BEEF;
`endif

  reg_file_32 #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .clr       (clr),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  always @(posedge clk) chk_d <= rd_chk;

  always @(negedge clk) begin
    if (count_en && busy) busy_cycles++;
    if (chk_d) begin
      if (qa.size() == 0) begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end else begin
        string nm;
        logic [31:0] ea, eb;
        nm = qn.pop_front();
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk({nm, ".a"}, rd_data_a, ea);
        chk({nm, ".b"}, rd_data_b, eb);
      end
    end
  end

  task automatic issue(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb, input logic c,
                       input bit do_chk, input logic [31:0] ea, input logic [31:0] eb,
                       input string nm);
    we = w; wr_addr = wa; wr_data = wd;
    rd_addr_a = ra; rd_addr_b = rb; clr = c;
    rd_chk = do_chk;
    if (do_chk) begin
      qa.push_back(ea);
      qb.push_back(eb);
      qn.push_back(nm);
    end
  endtask

  task automatic cyc(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                     input logic [4:0] ra, input logic [4:0] rb, input logic c,
                     input bit do_chk, input logic [31:0] ea, input logic [31:0] eb,
                     input string nm);
    @(negedge clk);
    issue(w, wa, wd, ra, rb, c, do_chk, ea, eb, nm);
  endtask

  initial begin
    bit done;
    #1 rst = 1'b1;
    #1;
    chk("reset_rd_a", rd_data_a, 32'h0);
    chk("reset_rd_b", rd_data_b, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic writes and reads
    cyc(1, 5'd3, 32'h0000_0039, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 5'd4, 32'h0000_0003, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 5'd3, 5'd4, 0, 1, 32'h0000_0039, 32'h0000_0003, "rd_3_4");
    cyc(1, 5'd7, 32'h0000_0002, 5'd7, 5'd3, 0, 1, 32'h0000_0002, 32'h0000_0039, "bypass_7");
    cyc(0, 0, 0, 5'd4, 5'd4, 0, 1, 32'h0000_0003, 32'h0000_0003, "same_addr");
    cyc(1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd31, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, "bypass_31");
    cyc(0, 0, 0, 5'd7, 5'd31, 0, 1, 32'h0000_0002, 32'hCAFE_F00D, "rd_7_31");

    // Fill, then clear with concurrent write attempts
    for (int i = 0; i < 32; i++) cyc(1, 5'(i), 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 5'd0, 5'd31, 0, 1, FILL0, 32'hFFFF_FFFF, "fill_read");
    busy_cycles = 0;
    count_en = 1'b1;
    cyc(1, 5'd5, 32'hA5A5_A5A5, 5'd5, 5'd0, 1, 1, 32'hFFFF_FFFF, FILL0, "clr_edge");
    cyc(1, 5'd2, 32'h1111_1111, 5'd0, 5'd2, 0, 1, 32'h0, 32'hFFFF_FFFF, "clr_e0");
    cyc(1, 5'd2, 32'h1111_1111, 5'd2, 5'd1, 1, 1, 32'hFFFF_FFFF, 32'h0, "clr_e1");
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
      issue(1, 5'(i), 32'h5555_5555, 5'd31, 5'd31, 1, 0, 0, 0, "");
    end
    chk("clear_done", {31'b0, done}, 32'd1);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    @(negedge clk);
    count_en = 1'b0;
    chk("busy_cycles", 32'(busy_cycles), 32'd32);
    chk("busy_idle", {31'b0, busy}, 32'h0);
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 5'(i), 5'(31 - i), 0, 1, 32'h0, 32'h0, "cleared");

    // Entry 0 behaviour and post-clear write acceptance
    cyc(1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0, 0, 1, BEEF0, BEEF0, "wr0_bypass");
    cyc(0, 0, 0, 5'd0, 5'd5, 0, 1, BEEF0, 32'h0, "rd0");

    // Reset in the middle of a clear
    cyc(1, 5'd20, 32'h0000_2020, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 5'd20, 5'd20, 1, 0, 0, 0, "");
    repeat (9) cyc(0, 0, 0, 5'd20, 5'd20, 0, 0, 0, 0, "");
    chk("pre_rst_rd_a", rd_data_a, 32'h0000_2020);
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    issue(1, 5'd10, 32'h0000_0BAD, 5'd20, 5'd20, 0, 0, 0, 0, "");
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_rd_a", rd_data_a, 32'h0);
    chk("rst_rd_b", rd_data_b, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(1, 5'd9, 32'h1234_5678, 5'd9, 5'd20, 0, 1, 32'h1234_5678, 32'h0, "post_rst_wr");
    cyc(0, 0, 0, 5'd9, 5'd10, 0, 1, 32'h1234_5678, 32'h0, "post_rst_rd");
    cyc(0, 0, 0, 5'd3, 5'd31, 0, 1, 32'h0, 32'h0, "post_rst_zero");

    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "");
    done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (qa.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("scoreboard_drained", {31'b0, done}, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
